// File: rtl/cvsd_pkg.sv
// rtl/cvsd_pkg.sv - shared constants and state type for the CVSD tone path
// Holds the sine table geometry, the downstream midscale code and the
// burst sequencer state enum.
package cvsd_pkg;

    localparam int         LUT_DEPTH = 20;
    localparam int         IDX_W     = 5;
    localparam logic [7:0] MIDSCALE  = 8'd128;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        RUN  = 2'd1,
        GAP  = 2'd2,
        DONE = 2'd3
    } burst_state_t;

endpackage

// File: rtl/tone_idx_acc.sv
// rtl/tone_idx_acc.sv - modulo-LUT_DEPTH sine table index accumulator
// Ports:
//   clk, rst_n  sample clock, asynchronous active-low reset
//   clear       force idx to 0 on the next edge (wins over advance)
//   advance     idx <= (idx + step) mod LUT_DEPTH on the next edge
//   step        increment, expected in 1..LUT_DEPTH-1
//   idx         registered table index
//   wrap_next   combinational: idx + step reaches or passes LUT_DEPTH
module tone_idx_acc #(
    parameter int LUT_DEPTH = cvsd_pkg::LUT_DEPTH,
    parameter int IDX_W     = cvsd_pkg::IDX_W
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             clear,
    input  logic             advance,
    input  logic [IDX_W-1:0] step,
    output logic [IDX_W-1:0] idx,
    output logic             wrap_next
);

    localparam logic [IDX_W:0] DEPTH = (IDX_W + 1)'(LUT_DEPTH);

    logic [IDX_W-1:0] idx_q, idx_d;
    logic [IDX_W:0]   sum;
    logic [IDX_W:0]   sum_wrapped;

    // One extra bit so the sum of two in-range values cannot overflow.
    assign sum         = {1'b0, idx_q} + {1'b0, step};
    assign sum_wrapped = sum - DEPTH;
    assign wrap_next   = (sum >= DEPTH);

    always_comb begin
        idx_d = idx_q;
        if (clear) begin
            idx_d = '0;
        end else if (advance) begin
            idx_d = wrap_next ? sum_wrapped[IDX_W-1:0] : sum[IDX_W-1:0];
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            idx_q <= '0;
        end else begin
            idx_q <= idx_d;
        end
    end

    assign idx = idx_q;

endmodule

// File: rtl/tone_burst_ctrl.sv
// rtl/tone_burst_ctrl.sv - tone burst sequencer driving the sine lookup path
// Ports:
//   clk_10k, rst_n       sample clock, asynchronous active-low reset
//   start, abort         one-cycle request / cancel
//   cfg_step             index increment per sample
//   cfg_periods          full table wraps per burst
//   cfg_gap              silent samples between bursts
//   cfg_repeat           number of bursts, 0 = continuous
//   lut_idx, lut_en      table index and live-sample flag
//   mute                 inverse of lut_en
//   busy, done           sequence active / one-cycle completion pulse
//   burst_cnt            bursts completed in the current sequence
module tone_burst_ctrl #(
    parameter int LUT_DEPTH = cvsd_pkg::LUT_DEPTH,
    parameter int IDX_W     = cvsd_pkg::IDX_W,
    parameter int CNT_W     = 8,
    parameter int REP_W     = 4
) (
    input  logic             clk_10k,
    input  logic             rst_n,
    input  logic             start,
    input  logic             abort,
    input  logic [IDX_W-1:0] cfg_step,
    input  logic [CNT_W-1:0] cfg_periods,
    input  logic [CNT_W-1:0] cfg_gap,
    input  logic [REP_W-1:0] cfg_repeat,
    output logic [IDX_W-1:0] lut_idx,
    output logic             lut_en,
    output logic             mute,
    output logic             busy,
    output logic             done,
    output logic [REP_W-1:0] burst_cnt
);

    import cvsd_pkg::*;

    localparam logic [IDX_W:0]   DEPTH_X  = (IDX_W + 1)'(LUT_DEPTH);
    localparam logic [IDX_W-1:0] STEP_ONE = IDX_W'(1);
    localparam logic [CNT_W-1:0] PER_ONE  = CNT_W'(1);

    burst_state_t     state_q, state_d;
    logic [IDX_W-1:0] step_q, step_d;
    logic [CNT_W-1:0] periods_q, periods_d;
    logic [CNT_W-1:0] gap_q, gap_d;
    logic [REP_W-1:0] repeat_q, repeat_d;
    logic [CNT_W-1:0] wrap_q, wrap_d;
    logic [CNT_W-1:0] gap_cnt_q, gap_cnt_d;
    logic [REP_W-1:0] burst_q, burst_d;
    logic             lut_en_q, mute_q, busy_q, done_q;

    logic             acc_clear, acc_adv, wrap_next;
    logic [CNT_W:0]   wrap_inc;
    logic [REP_W-1:0] burst_inc;
    logic             burst_end;
    logic             step_ok;

    tone_idx_acc #(
        .LUT_DEPTH (LUT_DEPTH),
        .IDX_W     (IDX_W)
    ) u_acc (
        .clk       (clk_10k),
        .rst_n     (rst_n),
        .clear     (acc_clear),
        .advance   (acc_adv),
        .step      (step_q),
        .idx       (lut_idx),
        .wrap_next (wrap_next)
    );

    assign step_ok   = (cfg_step != '0) && ({1'b0, cfg_step} < DEPTH_X);
    assign wrap_inc  = {1'b0, wrap_q} + 1'b1;
    assign burst_inc = burst_q + 1'b1;
    // The sample that would wrap for the periods-th time is the last one;
    // the wrapped index itself is never emitted.
    assign burst_end = wrap_next && (wrap_inc == {1'b0, periods_q});

    always_comb begin
        state_d   = state_q;
        step_d    = step_q;
        periods_d = periods_q;
        gap_d     = gap_q;
        repeat_d  = repeat_q;
        wrap_d    = wrap_q;
        gap_cnt_d = gap_cnt_q;
        burst_d   = burst_q;
        acc_clear = 1'b0;
        acc_adv   = 1'b0;

        unique case (state_q)
            IDLE: begin
                acc_clear = 1'b1;
                if (start && !abort) begin
                    state_d   = RUN;
                    step_d    = step_ok ? cfg_step : STEP_ONE;
                    periods_d = (cfg_periods == '0) ? PER_ONE : cfg_periods;
                    gap_d     = cfg_gap;
                    repeat_d  = cfg_repeat;
                    wrap_d    = '0;
                    burst_d   = '0;
                end
            end
            RUN: begin
                if (burst_end) begin
                    burst_d   = burst_inc;
                    acc_clear = 1'b1;
                    wrap_d    = '0;
                    if ((repeat_q != '0) && (burst_inc == repeat_q)) begin
                        state_d = DONE;
                    end else if (gap_q == '0) begin
                        state_d = RUN;
                    end else begin
                        state_d   = GAP;
                        gap_cnt_d = gap_q;
                    end
                end else begin
                    acc_adv = 1'b1;
                    if (wrap_next) begin
                        wrap_d = wrap_q + 1'b1;
                    end
                end
            end
            GAP: begin
                acc_clear = 1'b1;
                // Loaded with gap on entry, so GAP lasts exactly gap cycles.
                if (gap_cnt_q <= PER_ONE) begin
                    state_d   = RUN;
                    wrap_d    = '0;
                    gap_cnt_d = '0;
                end else begin
                    gap_cnt_d = gap_cnt_q - 1'b1;
                end
            end
            DONE: begin
                acc_clear = 1'b1;
                state_d   = IDLE;
            end
            default: begin
                state_d = IDLE;
            end
        endcase

        // Cancel overrides everything; burst_cnt is left for inspection.
        if (abort) begin
            state_d   = IDLE;
            acc_clear = 1'b1;
            acc_adv   = 1'b0;
            burst_d   = burst_q;
            wrap_d    = '0;
            gap_cnt_d = '0;
        end
    end

    always_ff @(posedge clk_10k or negedge rst_n) begin
        if (!rst_n) begin
            state_q   <= IDLE;
            step_q    <= '0;
            periods_q <= '0;
            gap_q     <= '0;
            repeat_q  <= '0;
            wrap_q    <= '0;
            gap_cnt_q <= '0;
            burst_q   <= '0;
            lut_en_q  <= 1'b0;
            mute_q    <= 1'b1;
            busy_q    <= 1'b0;
            done_q    <= 1'b0;
        end else begin
            state_q   <= state_d;
            step_q    <= step_d;
            periods_q <= periods_d;
            gap_q     <= gap_d;
            repeat_q  <= repeat_d;
            wrap_q    <= wrap_d;
            gap_cnt_q <= gap_cnt_d;
            burst_q   <= burst_d;
            lut_en_q  <= (state_d == RUN);
            mute_q    <= (state_d != RUN);
            busy_q    <= (state_d != IDLE);
            done_q    <= (state_d == DONE);
        end
    end

    assign lut_en    = lut_en_q;
    assign mute      = mute_q;
    assign busy      = busy_q;
    assign done      = done_q;
    assign burst_cnt = burst_q;

endmodule

// File: tb/tb_tone_burst_ctrl.sv
// tb/tb_tone_burst_ctrl.sv - scoreboard bench for tone_burst_ctrl
module tb_tone_burst_ctrl;

    localparam int DEPTH = 20;

    typedef struct packed {
        logic       en;
        logic [4:0] idx;
        logic       done;
        logic       busy;
        logic       mute;
        logic [3:0] burst;
    } rec_t;

    logic       clk_10k = 1'b0;
    logic       rst_n   = 1'b1;
    logic       start   = 1'b0;
    logic       abort   = 1'b0;
    logic [4:0] cfg_step    = '0;
    logic [7:0] cfg_periods = '0;
    logic [7:0] cfg_gap     = '0;
    logic [3:0] cfg_repeat  = '0;
    logic [4:0] lut_idx;
    logic       lut_en, mute, busy, done;
    logic [3:0] burst_cnt;

    int   vectors     = 0;
    int   miscompares = 0;
    int   model_burst = 0;
    rec_t sb[$];
    rec_t exp_q[$];

    tone_burst_ctrl dut (
        .clk_10k     (clk_10k),
        .rst_n       (rst_n),
        .start       (start),
        .abort       (abort),
        .cfg_step    (cfg_step),
        .cfg_periods (cfg_periods),
        .cfg_gap     (cfg_gap),
        .cfg_repeat  (cfg_repeat),
        .lut_idx     (lut_idx),
        .lut_en      (lut_en),
        .mute        (mute),
        .busy        (busy),
        .done        (done),
        .burst_cnt   (burst_cnt)
    );

    always #5 clk_10k = ~clk_10k;

    function automatic rec_t mk(bit en, int idx, bit dn, bit bz, int b);
        rec_t r;
        r.en    = en;
        r.idx   = 5'(idx);
        r.done  = dn;
        r.busy  = bz;
        r.mute  = !en;
        r.burst = 4'(b);
        return r;
    endfunction

    // Monitor: one expected record per cycle while the scoreboard holds any.
    always @(negedge clk_10k) begin
        rec_t e, a;
        if (rst_n && sb.size() != 0) begin
            e = sb.pop_front();
            a.en = lut_en; a.idx = lut_idx; a.done = done;
            a.busy = busy; a.mute = mute; a.burst = burst_cnt;
            vectors++;
            if (a !== e) begin
                miscompares++;
                $display("FAIL sample t=%0t got en=%b idx=%0d done=%b busy=%b mute=%b bc=%0d want en=%b idx=%0d done=%b busy=%b mute=%b bc=%0d",
                         $time, a.en, a.idx, a.done, a.busy, a.mute, a.burst,
                         e.en, e.idx, e.done, e.busy, e.mute, e.burst);
            end
        end
    end

    task automatic check_reset(input string tag);
        vectors++;
        if ({lut_en, lut_idx, done, busy, mute, burst_cnt} !== {1'b0, 5'd0, 1'b0, 1'b0, 1'b1, 4'd0}) begin
            miscompares++;
            $display("FAIL %s got en=%b idx=%0d done=%b busy=%b mute=%b bc=%0d want en=0 idx=0 done=0 busy=0 mute=1 bc=0",
                     tag, lut_en, lut_idx, done, busy, mute, burst_cnt);
        end
    endtask

    // Reference: a burst emits (k*step) mod DEPTH for k < ceil(periods*DEPTH/step).
    // ab > 0: abort sampled at the edge ending the ab-th active cycle.
    task automatic gen_seq(input int st, input int pe, input int gp, input int rp, input int ab);
        int s, p, n, b, limit;
        bit fin;
        rec_t last;
        exp_q.delete();
        s = (st == 0 || st >= DEPTH) ? 1 : st;
        p = (pe == 0) ? 1 : pe;
        n = (p * DEPTH + s - 1) / s;
        b = 0;
        fin = 0;
        limit = (ab > 0) ? ab : 1000000;
        while (!fin && exp_q.size() < limit) begin
            for (int k = 0; k < n && exp_q.size() < limit; k++)
                exp_q.push_back(mk(1, (k * s) % DEPTH, 0, 1, b));
            if (exp_q.size() >= limit) break;
            b = (b + 1) % 16;
            if (rp != 0 && b == rp) begin
                exp_q.push_back(mk(0, 0, 1, 1, b));
                fin = 1;
            end else begin
                for (int g = 0; g < gp && exp_q.size() < limit; g++)
                    exp_q.push_back(mk(0, 0, 0, 1, b));
            end
        end
        while (exp_q.size() > limit) void'(exp_q.pop_back());
        last = exp_q[exp_q.size() - 1];
        exp_q.push_back(mk(0, 0, 0, 0, last.burst));
        model_burst = last.burst;
    endtask

    // Called #1 after a clock edge with the DUT idle.
    task automatic run_seq(input int st, input int pe, input int gp, input int rp, input int ab);
        gen_seq(st, pe, gp, rp, ab);
        cfg_step    = 5'(st);
        cfg_periods = 8'(pe);
        cfg_gap     = 8'(gp);
        cfg_repeat  = 4'(rp);
        start = 1'b1;
        @(posedge clk_10k);
        #1;
        start = 1'b0;
        foreach (exp_q[i]) sb.push_back(exp_q[i]);
        for (int j = 1; j <= 2000; j++) begin
            if (sb.size() == 0) break;
            // Shadowed config must make these mid-sequence changes invisible.
            cfg_step    = 5'($urandom);
            cfg_periods = 8'($urandom);
            cfg_gap     = 8'($urandom);
            cfg_repeat  = 4'($urandom);
            if (j == ab)
                abort = 1'b1;
            else if (j - 1 < exp_q.size() && exp_q[j - 1].busy && $urandom_range(0, 7) == 0)
                start = 1'b1;
            @(posedge clk_10k);
            #1;
            abort = 1'b0;
            start = 1'b0;
        end
        if (sb.size() != 0) begin
            miscompares++;
            $display("FAIL seq_timeout got %0d records pending want 0", sb.size());
            sb.delete();
        end
    endtask

    task automatic start_abort_idle();
        cfg_step    = 5'd1;
        cfg_periods = 8'd1;
        cfg_repeat  = 4'd1;
        start = 1'b1;
        abort = 1'b1;
        @(posedge clk_10k);
        #1;
        start = 1'b0;
        abort = 1'b0;
        for (int i = 0; i < 3; i++) sb.push_back(mk(0, 0, 0, 0, model_burst));
        for (int j = 0; j < 10 && sb.size() != 0; j++) begin
            @(posedge clk_10k);
            #1;
        end
        if (sb.size() != 0) begin
            miscompares++;
            $display("FAIL start_abort_timeout got %0d pending want 0", sb.size());
            sb.delete();
        end
    endtask

    initial begin
        #1 rst_n = 1'b0;
        #1 check_reset("reset_values");
        @(posedge clk_10k);
        @(posedge clk_10k);
        #1 rst_n = 1'b1;

        run_seq(1, 2, 3, 2, -1);
        run_seq(3, 1, 0, 1, -1);
        run_seq(0, 0, 5, 1, -1);
        run_seq(1, 1, 0, 0, 17 * DEPTH + 7);
        start_abort_idle();

        for (int t = 0; t < 12; t++) begin
            int ab;
            ab = ($urandom_range(0, 3) == 0) ? int'($urandom_range(1, 40)) : -1;
            run_seq(int'($urandom_range(0, 31)), int'($urandom_range(0, 3)),
                    int'($urandom_range(0, 4)), int'($urandom_range(1, 3)), ab);
        end

        // Asynchronous reset in the middle of a burst.
        cfg_step = 5'd1; cfg_periods = 8'd2; cfg_gap = 8'd0; cfg_repeat = 4'd2;
        start = 1'b1;
        @(posedge clk_10k);
        #1 start = 1'b0;
        repeat (10) @(posedge clk_10k);
        #2;
        sb.delete();
        rst_n = 1'b0;
        #1 check_reset("async_reset_midrun");
        @(posedge clk_10k);
        #1 check_reset("reset_held");
        rst_n = 1'b1;
        model_burst = 0;

        run_seq(2, 1, 1, 2, -1);

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule

// File: doc/tone_burst_ctrl.md
# tone_burst_ctrl

Sequencer for the 20-entry sine lookup datapath in the CVSD test path. It turns a one-cycle `start` into a programmed train of tone bursts separated by silent gaps. Per sample it produces the lookup index, a lookup enable and a mute flag. The downstream sine table and CVSD encoder run one sample per `clk_10k` cycle and take all their sequencing from this block.

## Interface
- `LUT_DEPTH`, 20: number of sine table entries; index wraps modulo this value.
- `IDX_W`, 5: width of the table index.
- `CNT_W`, 8: width of the periods and gap fields.
- `REP_W`, 4: width of the repeat and burst-count fields.

- `clk_10k`  in  1  sample clock. One sample per cycle.
- `rst_n`  in  1  asynchronous, active-low reset.
- `start`  in  1  one-cycle request. Only accepted in IDLE.
- `abort`  in  1  one-cycle cancel. Accepted in any state.
- `cfg_step`  in  IDX_W  index increment per sample. Valid range 1..LUT_DEPTH-1.
- `cfg_periods`  in  CNT_W  full table wraps per burst.
- `cfg_gap`  in  CNT_W  number of silent samples after each burst except the last.
- `cfg_repeat`  in  REP_W  number of bursts. 0 means continuous until `abort`.
- `lut_idx`  out  IDX_W  sine table index.
- `lut_en`  out  1  `lut_idx` is a live sample this cycle.
- `mute`  out  1  downstream substitutes midscale 128. Equals `~lut_en`.
- `busy`  out  1  state is not IDLE.
- `done`  out  1  one-cycle pulse when a finite sequence completes.
- `burst_cnt`  out  REP_W  number of bursts completed in the current sequence.

## Operation
- States: IDLE, RUN, GAP, DONE. Encoding is a 2-bit enum.
- IDLE, with `start` high and `abort` low:
  - latch all `cfg_*` inputs into shadow registers;
  - go to RUN with `lut_idx`=0 and `burst_cnt`=0.
- Config changes while busy have no effect; only the shadow registers are used.
- Sanitising at latch time:
  - `cfg_step` of 0 or ≥LUT_DEPTH is treated as 1;
  - `cfg_periods`=0 is treated as 1.
- RUN:
  - one sample per cycle, `lut_en`=1;
  - next index sum = `lut_idx`+step. If sum ≥ LUT_DEPTH, next index = sum−LUT_DEPTH and `wrap_cnt` increments.
  - The burst ends on the cycle whose computed next index wraps and `wrap_cnt`+1 equals periods. The wrapped index is never emitted.
- At burst end, `burst_cnt` increments. Then:
  - if `cfg_repeat`≠0 and the new `burst_cnt` equals repeat, go to DONE. No trailing gap.
  - else if gap=0, go straight back to RUN with `lut_idx`=0 and `wrap_cnt`=0.
  - else go to GAP.
- GAP:
  - `lut_en`=0 and `lut_idx` holds 0 for exactly gap cycles;
  - then RUN with `lut_idx`=0 and `wrap_cnt`=0.
- DONE: `done`=1 and `busy`=1 for one cycle, then IDLE.
- `abort` from any state goes to IDLE on the next edge:
  - `lut_en`=0, `lut_idx`=0, `done` not pulsed;
  - `burst_cnt` holds its value for inspection.
- `start` and `abort` high together in IDLE: `abort` wins and the start is ignored.
- `start` while busy is ignored.
- Continuous mode (`cfg_repeat`=0): `burst_cnt` wraps modulo 2^REP_W and never causes DONE.

## Timing
- All outputs are registered.
- Reset values: `lut_idx`=0, `lut_en`=0, `mute`=1, `busy`=0, `done`=0, `burst_cnt`=0, state IDLE. Shadow registers and `wrap_cnt` also reset to 0.
- Start latency: `start` sampled at edge T gives the first live sample (`lut_idx`=0, `lut_en`=1) in the cycle after T.
- Burst length in samples = ceil(periods×LUT_DEPTH/step) when step divides evenly. In general it is the number of indices emitted before the periods-th wrap.
- Gap: exactly gap cycles with `lut_en`=0 between the last sample of one burst and index 0 of the next.
- `done` is asserted in the cycle after the last live sample. `busy` falls one cycle later.
- Abort: takes effect at the sampling edge. The next cycle shows `lut_en`=0 and `busy`=0.

## Structure
- Shared package `cvsd_pkg` holds:
  - `LUT_DEPTH`, `IDX_W`;
  - the state enum `burst_state_t` (IDLE/RUN/GAP/DONE);
  - the midscale constant `MIDSCALE`=128.
- Sub-module `tone_idx_acc`: modulo-LUT_DEPTH index accumulator.
  - Inputs: clear, advance, step.
  - Outputs: idx, and a combinational `wrap_next` flag.
- The FSM, the counters (`wrap_cnt`, gap counter, `burst_cnt`) and the shadow registers live in the top.

## Test plan
- Reset mid-RUN: assert `rst_n` low asynchronously. All outputs take their reset values immediately, with no clock edge needed.
- step=1, periods=2, gap=3, repeat=2, `start` at T:
  - `lut_en` high for T+1..T+40, with `lut_idx` sequence 0..19, 0..19;
  - low for T+41..T+43;
  - high for T+44..T+83;
  - `done` at T+84, `busy` low at T+85, `burst_cnt`=2.
- step=3, periods=1, repeat=1: `lut_idx` = 0, 3, 6, 9, 12, 15, 18 (7 samples), then `done`. Index 1 is never emitted.
- step=0, periods=0 latched: behaves exactly as step=1, periods=1, giving 20 samples 0..19.
- repeat=0, gap=0: back-to-back 0..19 bursts with no `lut_en` gap. `burst_cnt` wraps 15→0 and `done` never asserts. `abort` gives IDLE next cycle with no `done`.
- Config and handshake corners:
  - `start` while busy is ignored;
  - changing `cfg_step` during RUN does not alter the index sequence;
  - `start` and `abort` in the same IDLE cycle leave the block in IDLE with `busy`=0.
